// File: rtl/hack_data_memory.sv
// Hack-computer data memory: RAM, screen frame buffer and keyboard register behind one
// CPU port with registered reads, a sticky unmapped-access fault and a screen scan-out engine.
module hack_data_memory #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 15,
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int CONTINUOUS   = 0,
  localparam int SCR_AW      = $clog2(SCREEN_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              fault,
  input  logic              fault_clr,
  input  logic [DATA_W-1:0] kb_in,
  input  logic              scan_start,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  output logic [SCR_AW-1:0] scan_idx,
  output logic              scan_done,
  output logic              scan_busy
);

  localparam int RAM_AW      = $clog2(RAM_WORDS);
  localparam int SCREEN_BASE = RAM_WORDS;
  localparam int KBD_ADDR    = RAM_WORDS + SCREEN_WORDS;
  localparam logic [SCR_AW-1:0] LAST_IDX = SCR_AW'(SCREEN_WORDS - 1);

  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_SCR, SEL_KBD} sel_t;
  typedef enum logic {IDLE, RUN} state_t;

  logic [DATA_W-1:0] ram    [RAM_WORDS];
  logic [DATA_W-1:0] screen [SCREEN_WORDS];

  logic [31:0]       adr_w;
  logic              is_ram, is_scr, is_kbd, is_unm;
  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_off, scr_addr;
  logic              new_fault;

  state_t            state, state_nxt;
  logic [SCR_AW-1:0] ptr, ptr_nxt;
  logic              issue;

  sel_t              sel_p0;
  logic [DATA_W-1:0] kbd_reg, kbd_p0, ram_p0, scr_p0;
  logic              vld_p0, last_p0;
  logic [SCR_AW-1:0] idx_p0;

  assign adr_w   = 32'(adr);
  assign is_ram  = adr_w < 32'(RAM_WORDS);
  assign is_scr  = (adr_w >= 32'(SCREEN_BASE)) && (adr_w < 32'(KBD_ADDR));
  assign is_kbd  = adr_w == 32'(KBD_ADDR);
  assign is_unm  = adr_w > 32'(KBD_ADDR);
  assign ram_idx = adr[RAM_AW-1:0];
  assign scr_off = SCR_AW'(adr_w - 32'(SCREEN_BASE));
  // The screen bank has a single port; any CPU screen access owns it this cycle.
  assign scr_addr  = is_scr ? scr_off : ptr;
  assign new_fault = is_unm || (load && is_kbd);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end
      end
      RUN: begin
        if (!is_scr) begin
          issue = 1'b1;
          if (ptr == LAST_IDX) begin
            ptr_nxt = '0;
            if (CONTINUOUS == 0) state_nxt = IDLE;
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: memory read registers (read-before-write on a same-address write)
  always_ff @(posedge clk) begin
    if (load && is_ram) ram[ram_idx] <= d_in;
    ram_p0 <= ram[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (load && is_scr) screen[scr_off] <= d_in;
    scr_p0 <= screen[scr_addr];
  end

  always_ff @(posedge clk) begin
    kbd_p0 <= kbd_reg;
    idx_p0 <= ptr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_p0  <= SEL_ZERO;
      kbd_reg <= '0;
      fault   <= 1'b0;
      state   <= IDLE;
      ptr     <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      if (is_ram)      sel_p0 <= SEL_RAM;
      else if (is_scr) sel_p0 <= SEL_SCR;
      else if (is_kbd) sel_p0 <= SEL_KBD;
      else             sel_p0 <= SEL_ZERO;
      kbd_reg <= kb_in;
      fault   <= new_fault || (fault && !fault_clr);
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      vld_p0  <= issue;
      last_p0 <= issue && (ptr == LAST_IDX);
    end
  end

  always_comb begin
    d_out = '0;
    case (sel_p0)
      SEL_RAM:  d_out = ram_p0;
      SEL_SCR:  d_out = scr_p0;
      SEL_KBD:  d_out = kbd_p0;
      default:  d_out = '0;
    endcase
  end

  // Stage p1: scan-out presentation registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
      scan_data  <= '0;
      scan_idx   <= '0;
    end else begin
      scan_valid <= vld_p0;
      scan_done  <= last_p0;
      scan_data  <= vld_p0 ? scr_p0 : '0;
      if (vld_p0) scan_idx <= idx_p0;
    end
  end

  assign scan_busy = (state == RUN);

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: CPU decode/fault/keyboard vectors plus
// single-frame, stalled-frame and continuous-mode-with-reset scan-out sequences.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset, reset_c;
  logic        load, fault_clr, scan_start, scan_start_c;
  logic [14:0] adr;
  logic [15:0] d_in, kb_in;

  logic [15:0] dout, sd, dout_c, sd_c;
  logic [12:0] si, si_c;
  logic        fault, sv, sdone, sbusy;
  logic        fault_c, sv_c, sdone_c, sbusy_c;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hack_data_memory #(.CONTINUOUS(0)) dut (
    .clk(clk), .reset(reset), .load(load), .adr(adr), .d_in(d_in), .d_out(dout),
    .fault(fault), .fault_clr(fault_clr), .kb_in(kb_in), .scan_start(scan_start),
    .scan_valid(sv), .scan_data(sd), .scan_idx(si), .scan_done(sdone), .scan_busy(sbusy));

  hack_data_memory #(.CONTINUOUS(1)) dut_c (
    .clk(clk), .reset(reset_c), .load(load), .adr(adr), .d_in(d_in), .d_out(dout_c),
    .fault(fault_c), .fault_clr(fault_clr), .kb_in(kb_in), .scan_start(scan_start_c),
    .scan_valid(sv_c), .scan_data(sd_c), .scan_idx(si_c), .scan_done(sdone_c),
    .scan_busy(sbusy_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        load;
    logic [14:0] adr;
    logic [15:0] din;
    logic        fclr;
    logic        chk;
    logic [15:0] exp_d;
    logic        exp_f;
  } vec_t;

  vec_t vecs [20];

  initial begin
    int exp_idx, errs, done_cyc, gaps, frame, dones, hit;
    logic busy_at_done;

    vecs[0]  = '{1'b1, 15'd5,     16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 15'd16387, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 15'd5,     16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0};
    vecs[3]  = '{1'b0, 15'd16387, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b0, 15'd24576, 16'h0000, 1'b0, 1'b1, 16'h0041, 1'b0};
    vecs[5]  = '{1'b1, 15'd24576, 16'hFFFF, 1'b0, 1'b1, 16'h0041, 1'b1};
    vecs[6]  = '{1'b0, 15'd24576, 16'h0000, 1'b0, 1'b1, 16'h0041, 1'b1};
    vecs[7]  = '{1'b0, 15'd5,     16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0};
    vecs[8]  = '{1'b0, 15'd24577, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 15'd32767, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 15'd5,     16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0};
    vecs[11] = '{1'b1, 15'd7,     16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 15'd7,     16'h0002, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[13] = '{1'b0, 15'd7,     16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0};
    vecs[14] = '{1'b1, 15'd32767, 16'h1111, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[15] = '{1'b0, 15'd16387, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0};
    vecs[16] = '{1'b1, 15'd16383, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[17] = '{1'b0, 15'd16383, 16'h0000, 1'b0, 1'b1, 16'hAAAA, 1'b0};
    vecs[18] = '{1'b1, 15'd24575, 16'h5555, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[19] = '{1'b0, 15'd24575, 16'h0000, 1'b0, 1'b1, 16'h5555, 1'b0};

    reset = 1'b0; reset_c = 1'b0;
    load = 1'b0; adr = '0; d_in = '0; kb_in = 16'h0041; fault_clr = 1'b0;
    scan_start = 1'b0; scan_start_c = 1'b0;
    #2;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_scan", 32'({sv, sd, si, sdone, sbusy}), 32'h0);
    @(negedge clk);
    reset = 1'b1; reset_c = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load = vecs[i].load; adr = vecs[i].adr; d_in = vecs[i].din; fault_clr = vecs[i].fclr;
      @(posedge clk); #1;
      if (vecs[i].chk) check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_d));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].exp_f));
    end

    // Keyboard path: two edges from kb_in to d_out
    @(negedge clk);
    load = 1'b0; fault_clr = 1'b0; adr = 15'd24576; kb_in = 16'h0077;
    @(posedge clk); #1;
    check("kbd_lat1", 32'(dout), 32'h0041);
    @(posedge clk); #1;
    check("kbd_lat2", 32'(dout), 32'h0077);

    // Fill the frame buffer with data = index
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      load = 1'b1; adr = 15'(16384 + i); d_in = 16'(i);
    end
    @(negedge clk);
    load = 1'b0; adr = '0;

    // Single frame, no CPU screen traffic
    exp_idx = 0; errs = 0; done_cyc = -1; busy_at_done = 1'b1;
    scan_start = 1'b1;
    @(posedge clk); #1;
    check("busy_start", 32'(sbusy), 32'h1);
    @(negedge clk);
    scan_start = 1'b0;
    for (int c = 1; c <= 9000; c++) begin
      @(posedge clk); #1;
      if (sv) begin
        if (sd != 16'(exp_idx) || si != 13'(exp_idx)) errs++;
        exp_idx++;
      end
      if (sdone) begin
        done_cyc = c; busy_at_done = sbusy;
        check("f1_done_idx", 32'(si), 32'd8191);
        break;
      end
    end
    check("f1_seq_errs", 32'(errs), 32'h0);
    check("f1_words", 32'(exp_idx), 32'd8192);
    check("f1_cycles", 32'(done_cyc), 32'd8193);
    check("f1_busy_drop", 32'(busy_at_done), 32'h0);
    @(posedge clk); #1;
    check("f1_done_pulse", 32'({sv, sdone, sbusy}), 32'h0);

    // Frame with 10 stalling CPU screen reads
    exp_idx = 0; errs = 0; done_cyc = -1; gaps = 0;
    @(negedge clk);
    scan_start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 9000; c++) begin
      logic stall;
      stall = (c >= 100) && (c <= 4600) && (c % 500 == 100);
      @(negedge clk);
      scan_start = 1'b0;
      adr = stall ? 15'(16384 + c) : 15'd0;
      @(posedge clk); #1;
      if (stall) check($sformatf("stall%0d_dout", c), 32'(dout), 32'(c));
      if (sv) begin
        if (sd != 16'(exp_idx) || si != 13'(exp_idx)) errs++;
        exp_idx++;
      end else if (exp_idx > 0 && !sdone) begin
        gaps++;
      end
      if (sdone) begin
        done_cyc = c;
        break;
      end
    end
    adr = '0;
    check("f2_seq_errs", 32'(errs), 32'h0);
    check("f2_words", 32'(exp_idx), 32'd8192);
    check("f2_gaps", 32'(gaps), 32'd10);
    check("f2_cycles", 32'(done_cyc), 32'd8203);

    // Continuous mode: reset at idx 100 of the second frame
    exp_idx = 0; errs = 0; frame = 1; dones = 0; hit = 0;
    @(negedge clk);
    scan_start_c = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    scan_start_c = 1'b0;
    for (int c = 1; c <= 20000; c++) begin
      @(posedge clk); #1;
      if (sdone_c) dones++;
      if (sv_c) begin
        if (sd_c != 16'(exp_idx) || si_c != 13'(exp_idx)) errs++;
        if (sdone_c != (exp_idx == 8191)) errs++;
        if (frame == 2 && exp_idx == 100) begin
          hit = 1;
          break;
        end
        if (exp_idx == 8191) begin
          frame++;
          exp_idx = 0;
        end else begin
          exp_idx++;
        end
      end
    end
    check("c_reached", 32'(hit), 32'h1);
    check("c_seq_errs", 32'(errs), 32'h0);
    check("c_dones", 32'(dones), 32'h1);
    check("c_busy_pre", 32'(sbusy_c), 32'h1);
    reset_c = 1'b0;
    #1;
    check("c_rst_dout", 32'(dout_c), 32'h0);
    check("c_rst_fault", 32'(fault_c), 32'h0);
    check("c_rst_scan", 32'({sv_c, sd_c, si_c, sdone_c, sbusy_c}), 32'h0);
    errs = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (sv_c || sdone_c || sbusy_c) errs++;
    end
    check("c_rst_hold", 32'(errs), 32'h0);
    @(negedge clk);
    reset_c = 1'b1;
    @(negedge clk);
    scan_start_c = 1'b1;
    @(posedge clk); #1;
    check("c_restart_busy", 32'(sbusy_c), 32'h1);
    @(negedge clk);
    scan_start_c = 1'b0;
    @(posedge clk); #1;
    check("c_restart_lat", 32'(sv_c), 32'h0);
    @(posedge clk); #1;
    check("c_restart_first", 32'({sv_c, si_c, sd_c}), 32'({1'b1, 13'd0, 16'd0}));
    @(posedge clk); #1;
    check("c_restart_second", 32'({sv_c, si_c, sd_c}), 32'({1'b1, 13'd1, 16'd1}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
# hack_data_memory

Parametrised memory-mapped data memory for the 16-bit computer. The block holds the general RAM, the screen frame buffer and the keyboard register behind one CPU data port, and decodes the address into those regions. It adds three things: registered reads, a fault flag for unmapped accesses, and an autonomous screen scan-out engine. The scan-out engine streams the frame buffer to a display back-end and shares the screen bank with the CPU, with the CPU taking priority. It sits between the CPU data port and the display/keyboard I/O in the `computer` top.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 15, CPU address width
- RAM_WORDS, 16384, general RAM depth; RAM occupies 0..RAM_WORDS-1
- SCREEN_WORDS, 8192, frame buffer depth; screen base address is SCREEN_BASE = RAM_WORDS
- CONTINUOUS, 0, 1 = scan-out wraps forever, 0 = single frame per start
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- load  in  1  CPU write enable
- adr  in  ADDR_W  CPU address
- d_in  in  DATA_W  CPU write data
- d_out  out  DATA_W  CPU read data, registered
- fault  out  1  sticky unmapped-access flag
- fault_clr  in  1  synchronous clear of fault
- kb_in  in  DATA_W  raw keyboard code
- scan_start  in  1  start scan-out pulse
- scan_valid  out  1  scan_data/scan_idx valid this cycle
- scan_data  out  DATA_W  frame buffer word
- scan_idx  out  clog2(SCREEN_WORDS)  word index of scan_data
- scan_done  out  1  one-cycle pulse with last word of a frame
- scan_busy  out  1  engine in RUN

## Operation
- Address decode:
  - RAM: adr < RAM_WORDS
  - Screen: SCREEN_BASE..SCREEN_BASE+SCREEN_WORDS-1
  - Keyboard: KBD_ADDR = SCREEN_BASE+SCREEN_WORDS (24576 at defaults)
  - Unmapped: anything above KBD_ADDR
- CPU write (load=1): RAM and screen words are written on the clock edge.
  - A write to the keyboard address or to an unmapped address changes no storage and sets fault.
- CPU read: every cycle, d_out <= word at adr (read happens regardless of load).
  - Keyboard address returns kbd_reg.
  - Unmapped address returns 0 and sets fault.
- Same-cycle read and write of one address: d_out gets the old contents (read-before-write).
- kbd_reg <= kb_in every cycle, giving a one-cycle synchronising register.
- fault: sticky until fault_clr. If fault_clr and a new fault occur in the same cycle, fault stays 1.
- Scan-out FSM, states IDLE and RUN:
  - IDLE -> RUN on scan_start; ptr <= 0.
  - In RUN, the screen bank has one port. A cycle where the CPU reads or writes a screen address is a stall: no scan read is issued and ptr holds.
  - Otherwise the engine reads screen[ptr] and ptr increments.
  - A scan read issued at ptr = SCREEN_WORDS-1:
    - CONTINUOUS=0: -> IDLE.
    - CONTINUOUS=1: ptr wraps to 0 and the FSM stays in RUN.
  - scan_start while in RUN is ignored.
- scan_busy = (state == RUN).

## Timing
- Reset values:
  - d_out = 0, fault = 0, kbd_reg = 0
  - FSM in IDLE, ptr = 0
  - scan_valid = 0, scan_data = 0, scan_idx = 0, scan_done = 0, scan_busy = 0
  - RAM and screen contents are not reset.
- Reset asserted mid-frame aborts the scan immediately: all outputs go to their reset values and no scan_done is produced.
- CPU read latency is 1 cycle: adr sampled at edge N, d_out valid after edge N.
- Keyboard read latency from kb_in is 2 edges.
- Scan read issued at edge N: scan_valid, scan_data and scan_idx are presented after edge N+1, for one cycle.
- scan_done is coincident with the scan_valid of idx SCREEN_WORDS-1.
- With no CPU screen traffic, one frame from the scan_start edge to scan_done is SCREEN_WORDS+1 cycles. Each stall cycle adds exactly one cycle.
- scan_start sampled in the same cycle as the final IDLE transition (CONTINUOUS=0) is accepted only on the following cycle.
- A CPU write to screen[k] at edge N is seen by a scan read of k issued at edge N+1 or later.

## Test plan
- Reset then write RAM[5]=0x1234 and screen[SCREEN_BASE+3]=0xBEEF, then read both -> d_out 0x1234 and 0xBEEF one cycle after each address; fault=0.
- kb_in=0x0041, read 24576 -> d_out=0x0041. Write 24576 -> d_out unchanged on re-read and fault=1. Pulse fault_clr -> fault=0. Read 24577 -> d_out=0 and fault=1.
- Same-cycle write and read of RAM[7] (old 0x0001, new 0x0002) -> d_out=0x0001; next read returns 0x0002.
- Fill the screen with data = index, CONTINUOUS=0, pulse scan_start -> 8192 consecutive scan_valid with scan_data = scan_idx = 0..8191; scan_done with idx 8191; scan_busy drops; total 8193 cycles.
- During a scan, issue CPU screen reads on 10 cycles -> exactly 10 gaps in scan_valid, no index skipped or repeated, frame takes 8203 cycles.
- With CONTINUOUS=1, assert reset low at idx 100 of frame 2 -> all outputs 0 and IDLE immediately. A later scan_start restarts at idx 0.
